// File: rtl/node_stream_tx.sv
// Snapshots packed node-position buses on frame_start and streams one node per valid/ready beat.
// Define NODE_STREAM_CHECKSUM_EN to append an XOR trailer beat (index NODE_COUNT) to every frame.
module node_stream_tx #(
  parameter int NODE_COUNT = 10,
  parameter int IDX_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [NODE_COUNT*32-1:0] nodes_x,
  input  logic [NODE_COUNT*32-1:0] nodes_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic [31:0]              out_x,
  output logic [31:0]              out_y,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_drop,
  output logic [15:0]              frame_count
);

  typedef enum logic {IDLE, SEND} state_t;

`ifdef NODE_STREAM_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);
`endif

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [31:0]      snap_x [NODE_COUNT];
  logic [31:0]      snap_y [NODE_COUNT];

  logic xfer;
  logic at_last;
  logic capture;

  assign xfer    = out_valid && out_ready;
  assign at_last = (index == LAST_IDX);
  // A new frame is taken from IDLE, or back-to-back on the final transfer of the current one.
  assign capture = frame_start && ((state == IDLE) || (xfer && at_last));

  assign out_index = index;
  assign out_last  = out_valid && at_last;

  // NOTE: every sequential assignment uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      index       <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_drop  <= 1'b0;
      frame_count <= '0;
      // NOTE: the snapshot array is cleared on reset so out_x/out_y are defined before the first frame.
      for (int i = 0; i < NODE_COUNT; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
    end else begin
      frame_drop <= 1'b0;

      if (capture) begin
        for (int i = 0; i < NODE_COUNT; i++) begin
          snap_x[i] <= nodes_x[i*32 +: 32];
          snap_y[i] <= nodes_y[i*32 +: 32];
        end
      end

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            index     <= '0;
            state     <= SEND;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (xfer && at_last) begin
            frame_count <= frame_count + 16'd1;
            if (frame_start) begin
              index <= '0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            if (xfer) begin
              index <= index + IDX_W'(1);
            end
            if (frame_start) begin
              frame_drop <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NODE_STREAM_CHECKSUM_EN
  logic [31:0] chk_x;
  logic [31:0] chk_y;

  always_comb begin
    chk_x = '0;
    chk_y = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      chk_x = chk_x ^ snap_x[i];
      chk_y = chk_y ^ snap_y[i];
    end
  end
`endif

  // NOTE: defaults first so the index mux never infers a latch for out-of-range indices.
  always_comb begin
    out_x = '0;
    out_y = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (index == IDX_W'(i)) begin
        out_x = snap_x[i];
        out_y = snap_y[i];
      end
    end
`ifdef NODE_STREAM_CHECKSUM_EN
    if (index == LAST_IDX) begin
      out_x = chk_x;
      out_y = chk_y;
    end
`endif
  end

endmodule

// File: tb/tb_node_stream_tx.sv
// Directed bench for node_stream_tx: basic frame, backpressure, snapshot coherence,
// drop, back-to-back, mid-frame reset and (when enabled) the checksum trailer.
module tb_node_stream_tx;

  localparam int NC    = 10;
  localparam int IDX_W = 8;
`ifdef NODE_STREAM_CHECKSUM_EN
  localparam int BEATS = NC + 1;
`else
  localparam int BEATS = NC;
`endif

  logic             clk;
  logic             reset;
  logic             frame_start;
  logic [NC*32-1:0] nodes_x;
  logic [NC*32-1:0] nodes_y;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [31:0]      out_x;
  logic [31:0]      out_y;
  logic             out_last;
  logic             busy;
  logic             frame_drop;
  logic [15:0]      frame_count;

  node_stream_tx #(.NODE_COUNT(NC), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .nodes_x     (nodes_x),
    .nodes_y     (nodes_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_last    (out_last),
    .busy        (busy),
    .frame_drop  (frame_drop),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Node i carries base+i; the trailer beat carries the XOR of all node words.
  function automatic logic [31:0] exp_word(input logic [31:0] base, input int i);
    logic [31:0] acc;
    if (i < NC) return base + 32'(i);
    acc = '0;
    for (int k = 0; k < NC; k++) acc = acc ^ (base + 32'(k));
    return acc;
  endfunction

  task automatic load(input logic [31:0] xb, input logic [31:0] yb);
    for (int i = 0; i < NC; i++) begin
      nodes_x[i*32 +: 32] = xb + 32'(i);
      nodes_y[i*32 +: 32] = yb + 32'(i);
    end
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] xb, input logic [31:0] yb);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_index"}, 32'(out_index), 32'(i));
    check({tag, "_x"},     out_x, exp_word(xb, i));
    check({tag, "_y"},     out_y, exp_word(yb, i));
    check({tag, "_last"},  32'(out_last), 32'(i == BEATS - 1));
  endtask

  task automatic check_idle(input string tag, input logic [15:0] count);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_count"}, 32'(frame_count), 32'(count));
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    load(32'h100, 32'h200);
    repeat (2) @(negedge clk);

    // Reset state
    check_idle("rst", 16'd0);
    check("rst_drop",  32'(frame_drop), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_x",     out_x, 32'd0);
    check("rst_y",     out_y, 32'd0);

    reset = 1'b1;
    @(negedge clk);
    check_idle("idle", 16'd0);

    // Frame A: basic data, backpressure at 3, dropped request at 4, inputs change after capture
    frame_start = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    load(32'hDEAD0000, 32'hBEEF0000);
    for (int i = 0; i < BEATS; i++) begin
      frame_start = 1'b0;
      check_beat("a", i, 32'h100, 32'h200);
      if (i == 2) check("a_nodrop", 32'(frame_drop), 32'd0);
      if (i == 5) check("a_drop", 32'(frame_drop), 32'd1);
      if (i == 6) check("a_drop_end", 32'(frame_drop), 32'd0);
`ifdef NODE_STREAM_CHECKSUM_EN
      if (i == NC) begin
        check("a_chk_x", out_x, 32'h1);
        check("a_chk_y", out_y, 32'h1);
      end
`endif
      if (i == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_beat("hold", 3, 32'h100, 32'h200);
        end
        out_ready = 1'b1;
      end
      if (i == 4) frame_start = 1'b1;
      @(negedge clk);
    end
    check_idle("a_end", 16'd1);
    check("a_end_drop", 32'(frame_drop), 32'd0);

    // Frame B: carries the values changed after frame A's capture; back-to-back at the end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      check_beat("b", i, 32'hDEAD0000, 32'hBEEF0000);
      if (i == BEATS - 1) begin
        load(32'h300, 32'h400);
        frame_start = 1'b1;
      end
      @(negedge clk);
    end
    frame_start = 1'b0;

    // Frame C: back-to-back start, then reset at index 6
    check("b2b_count", 32'(frame_count), 32'd2);
    check("b2b_drop",  32'(frame_drop), 32'd0);
    for (int i = 0; i <= 6; i++) begin
      check_beat("c", i, 32'h300, 32'h400);
      if (i == 6) reset = 1'b0;
      @(negedge clk);
    end
    check_idle("mid_rst", 16'd0);
    check("mid_rst_index", 32'(out_index), 32'd0);
    reset = 1'b1;

    // Frame D: fresh start after reset, full frame
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      check_beat("d", i, 32'h300, 32'h400);
      @(negedge clk);
    end
    check_idle("d_end", 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_stream_tx.md
Name: node_stream_tx

Overview:
- Reader/transmitter for the packed node-position buses that the rope cores produce (32-bit x/y per node, node i in bits [(i+1)*32-1 : i*32]).
- On a frame trigger it snapshots every node position in one cycle.
- It then streams the positions one node per beat over a valid/ready interface, for a downstream renderer, UART bridge or debug capture.
- Because of the snapshot, a streamed frame stays coherent while the cores keep updating.

Parameters:
- NODE_COUNT, 10, total nodes across all cores (2 cores x 5 nodes).
- IDX_W, 8, width of out_index; must satisfy 2^IDX_W > NODE_COUNT.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low: reset==0 at a posedge resets the block.
- frame_start  input  1  one-cycle request to capture and stream a frame.
- nodes_x  input  NODE_COUNT*32  packed node x positions, node i at [(i+1)*32-1 : i*32].
- nodes_y  input  NODE_COUNT*32  packed node y positions, same layout.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  IDX_W  node index of the current beat.
- out_x  output  32  snapshot x of node out_index.
- out_y  output  32  snapshot y of node out_index.
- out_last  output  1  final beat of the frame.
- busy  output  1  a frame is being streamed.
- frame_drop  output  1  one-cycle pulse: frame_start was ignored.
- frame_count  output  16  number of completed frames, wraps.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; index=0; snapshot registers=0.
  - out_valid=0, out_last=0, busy=0, frame_drop=0, frame_count=0.
  - Reset during SEND abandons the frame: no last beat, frame_count not incremented.
- States: IDLE, SEND.
- IDLE:
  - busy=0, out_valid=0.
  - frame_start=1 at posedge: capture nodes_x/nodes_y into the snapshot, index<=0, go to SEND.
  - out_valid rises the next cycle (1-cycle latency from frame_start).
- SEND:
  - busy=1, out_valid=1.
  - out_index=index; out_x/out_y = snapshot word [index], a mux off registered state.
  - out_last = (index==NODE_COUNT-1).
- Handshake:
  - A transfer occurs when out_valid&&out_ready at a posedge.
  - Without a transfer, out_index/out_x/out_y/out_last hold stable; the frame cannot be cut short.
  - Transfer with out_last=0: index<=index+1.
  - Transfer with out_last=1: frame_count<=frame_count+1 (16-bit wrap 0xFFFF->0), then go to IDLE.
- frame_start in SEND, no final transfer that cycle: ignored, snapshot untouched, frame_drop=1 the next cycle.
- frame_start in the same cycle as the final transfer:
  - Accepted back-to-back: new snapshot captured, index<=0, state stays SEND, out_valid stays 1, frame_count still increments.
  - No frame_drop.
- nodes_x/nodes_y changes after capture have no effect on the frame in flight.
- frame_drop is a single-cycle pulse. It is 0 whenever the previous cycle had no dropped request.

Optional Feature:
- Macro: NODE_STREAM_CHECKSUM_EN.
- Defined:
  - After node NODE_COUNT-1, one trailer beat is sent with out_index=NODE_COUNT, out_x = XOR of all snapshot x, out_y = XOR of all snapshot y.
  - out_last is asserted only on the trailer beat; the frame is NODE_COUNT+1 beats.
  - frame_count and back-to-back rules apply at the trailer transfer.
  - The XOR accumulators are computed from the snapshot and are valid when the trailer is presented.
- Undefined: no trailer, no accumulator logic; out_last on node NODE_COUNT-1.

Test Plan:
- Basic frame:
  - Stimulus: reset low 2 cycles, then high; node i x=0x100+i, y=0x200+i; out_ready=1; frame_start pulse.
  - Response: out_valid rises 1 cycle later; 10 consecutive beats with index 0..9, x 0x100..0x109, y 0x200..0x209; out_last only on index 9; frame_count=1; busy falls after beat 9.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at index 3.
  - Response: index 3, x=0x103, y=0x203 held stable all 5 cycles; no skipped or duplicated index once ready returns.
- Snapshot coherence:
  - Stimulus: change all inputs to x=0xDEAD0000+i right after capture.
  - Response: the streamed frame still carries 0x100+i; the next frame carries 0xDEAD0000+i.
- Drop and back-to-back:
  - Stimulus: frame_start at index 4.
  - Response: frame_drop pulses 1 cycle, frame unaffected.
  - Stimulus: frame_start coincident with the index-9 transfer.
  - Response: next cycle index=0 with new data, out_valid never drops, frame_count=2.
- Reset mid-frame:
  - Stimulus: reset=0 at index 6.
  - Response: next cycle out_valid=0, busy=0, frame_count=0; a fresh frame_start restarts at index 0.
- Checksum (NODE_STREAM_CHECKSUM_EN):
  - Stimulus: basic-frame data.
  - Response: 11th beat has index 10, x = XOR(0x100..0x109) = 0x00000001, y = XOR(0x200..0x209) = 0x00000001; out_last only on that beat.
